// File: rtl/mic_frame_buffer.sv
// Ping-pong frame buffer between the microphone deserialiser and the FFT input.
// Each rising edge of the level-style in_valid captures one sample. Samples fill
// one bank of FRAME_LEN entries while the other bank streams out over
// valid/ready. out_last marks the final beat of each frame.
module mic_frame_buffer #(
  parameter int W         = 16,
  parameter int FRAME_LEN = 256,
  parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
  input  logic         bclk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         overflow,
  input  logic         clear_overflow
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_STREAM} state_e;

  state_e            state_q;
  logic              in_valid_q;
  logic              wr_bank_q;
  logic              rd_bank_q;
  logic [ADDR_W-1:0] wr_idx_q;
  logic [ADDR_W-1:0] rd_idx_q;
  logic [ADDR_W-1:0] rd_addr_d;
  logic [1:0]        bank_full_q;
  logic              overflow_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [W-1:0]      rdata_q;
  logic [W-1:0]      mem [0:1][0:FRAME_LEN-1];

  logic capture;
  logic wr_en;
  logic drop;
  logic wr_done;
  logic hs;
  logic rel;

  // A bank stays FULL until its last beat is accepted, so FULL also covers
  // "being read"; a capture into such a bank is dropped.
  assign capture = in_valid & ~in_valid_q;
  assign wr_en   = capture & ~bank_full_q[wr_bank_q];
  assign drop    = capture &  bank_full_q[wr_bank_q];
  assign wr_done = wr_en & (wr_idx_q == LAST_IDX);
  assign hs      = out_valid_q & out_ready;
  assign rel     = hs & (rd_idx_q == LAST_IDX);

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = rdata_q;
  assign overflow  = overflow_q;

  // Read address runs one index ahead on a handshake so the RAM output
  // register already holds the next beat: no bubbles within a frame.
  always_comb begin
    rd_addr_d = rd_idx_q;
    if (hs && !rel) begin
      rd_addr_d = rd_idx_q + ADDR_W'(1);
    end
  end

  // Capture edge detect, write pointer and sticky overflow (set beats clear).
  always_ff @(posedge bclk) begin
    if (reset) begin
      in_valid_q <= 1'b1;
      wr_bank_q  <= 1'b0;
      wr_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      if (wr_en) begin
        if (wr_done) begin
          wr_bank_q <= ~wr_bank_q;
          wr_idx_q  <= '0;
        end else begin
          wr_idx_q  <= wr_idx_q + ADDR_W'(1);
        end
      end else if (drop) begin
        wr_idx_q <= '0;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clear_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Bank status: write side fills a bank, read side releases it.
  always_ff @(posedge bclk) begin
    if (reset) begin
      bank_full_q <= '0;
    end else begin
      if (wr_done) begin
        bank_full_q[wr_bank_q] <= 1'b1;
      end
      if (rel) begin
        bank_full_q[rd_bank_q] <= 1'b0;
      end
    end
  end

  // Sample storage write port.
  always_ff @(posedge bclk) begin
    if (wr_en) begin
      mem[wr_bank_q][wr_idx_q] <= in_data;
    end
  end

  // Synchronous read port; its output register is the streamed beat.
  always_ff @(posedge bclk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[rd_bank_q][rd_addr_d];
    end
  end

  // Read FSM: wait for a full bank, prime the RAM, then stream the frame.
  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rd_bank_q   <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bank_full_q[rd_bank_q]) begin
            state_q <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          state_q     <= ST_STREAM;
          out_valid_q <= 1'b1;
          out_last_q  <= 1'b0;
        end
        ST_STREAM: begin
          if (rel) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            rd_idx_q    <= '0;
            rd_bank_q   <= ~rd_bank_q;
            state_q     <= bank_full_q[~rd_bank_q] ? ST_PRIME : ST_IDLE;
          end else if (hs) begin
            rd_idx_q   <= rd_idx_q + ADDR_W'(1);
            out_last_q <= ((rd_idx_q + ADDR_W'(1)) == LAST_IDX);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Directed bench for mic_frame_buffer with FRAME_LEN=8.
module tb_mic_frame_buffer;

  localparam int W  = 16;
  localparam int FL = 8;

  logic          bclk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_ready = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          overflow;

  mic_frame_buffer #(.W(W), .FRAME_LEN(FL)) dut (
    .bclk           (bclk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  always #5 bclk = ~bclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rand_ready = 1'b0;

  logic [W-1:0] got_d[$];
  logic         got_l[$];
  int           got_c[$];

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic         prev_l = 1'b0;

  always @(posedge bclk) cyc <= cyc + 1;

  // Beat recorder and hold-while-stalled check.
  always @(negedge bclk) begin
    #1;
    if (prev_stall && !reset) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== prev_d || out_last !== prev_l) begin
        bad++;
        $display("FAIL hold_stable: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                 out_valid, out_data, out_last, prev_d, prev_l);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1 && !reset) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      got_c.push_back(cyc);
    end
    prev_stall = (out_valid === 1'b1 && out_ready === 1'b0 && !reset);
    prev_d     = out_data;
    prev_l     = out_last;
  end

  always @(negedge bclk) begin
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_got();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  task automatic send_sample(input logic [W-1:0] d, input int hi, input int lo);
    @(negedge bclk);
    in_data  = d;
    in_valid = 1'b1;
    repeat (hi) @(negedge bclk);
    in_valid = 1'b0;
    repeat (lo) @(negedge bclk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge bclk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", out_last); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rst_data: got %h want 0000", out_data); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    @(negedge bclk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_got();
    out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) send_sample(16'(i), 20, 12);
    @(negedge bclk);
    in_data  = 16'h0008;
    in_valid = 1'b1;
    @(negedge bclk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_cap: got %b want 0", out_valid); end
    @(negedge bclk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_plus1: got %b want 0", out_valid); end
    @(negedge bclk); #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_plus2: got %b want 1", out_valid); end
    repeat (17) @(negedge bclk);
    in_valid = 1'b0;
    repeat (12) @(negedge bclk);
    for (int k = 0; k < 400 && got_d.size() < FL; k++) @(negedge bclk);
    repeat (20) @(negedge bclk);
    total++; if (got_d.size() != FL) begin bad++; $display("FAIL basic_count: got %0d want %0d", got_d.size(), FL); end
    for (int i = 0; i < got_d.size() && i < FL; i++) begin
      total++;
      if (got_d[i] !== 16'(i + 1) || got_l[i] !== (i == FL - 1)) begin
        bad++;
        $display("FAIL basic_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], 16'(i + 1), (i == FL - 1));
      end
    end
  endtask

  task automatic test_level();
    logic [W-1:0] exp_d [FL];
    clear_got();
    out_ready = 1'b1;
    exp_d[0] = 16'h1234;
    for (int i = 1; i < FL; i++) exp_d[i] = 16'(i + 1);
    send_sample(16'h1234, 200, 12);
    for (int i = 1; i < FL; i++) send_sample(exp_d[i], 4, 4);
    for (int k = 0; k < 400 && got_d.size() < FL; k++) @(negedge bclk);
    repeat (20) @(negedge bclk);
    total++; if (got_d.size() != FL) begin bad++; $display("FAIL level_count: got %0d want %0d", got_d.size(), FL); end
    for (int i = 0; i < got_d.size() && i < FL; i++) begin
      total++;
      if (got_d[i] !== exp_d[i] || got_l[i] !== (i == FL - 1)) begin
        bad++;
        $display("FAIL level_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], exp_d[i], (i == FL - 1));
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_got();
    out_ready = 1'b1;
    for (int i = 0; i < 2 * FL; i++) send_sample(16'(16'h0C00 + i), 1, 1);
    for (int k = 0; k < 400 && got_d.size() < 2 * FL; k++) @(negedge bclk);
    repeat (20) @(negedge bclk);
    total++; if (got_d.size() != 2 * FL) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got_d.size(), 2 * FL); end
    for (int i = 0; i < got_d.size() && i < 2 * FL; i++) begin
      total++;
      if (got_d[i] !== 16'(16'h0C00 + i) || got_l[i] !== ((i % FL) == FL - 1)) begin
        bad++;
        $display("FAIL b2b_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], 16'(16'h0C00 + i), ((i % FL) == FL - 1));
      end
      if ((i % FL) != 0) begin
        total++;
        if (got_c[i] != got_c[i - 1] + 1) begin
          bad++;
          $display("FAIL b2b_gap%0d: got cycle %0d want %0d", i, got_c[i], got_c[i - 1] + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_got();
    rand_ready = 1'b1;
    for (int i = 1; i <= FL; i++) send_sample(16'(16'h0A00 + i), 3, 3);
    for (int k = 0; k < 600 && got_d.size() < FL; k++) @(negedge bclk);
    rand_ready = 1'b0;
    @(negedge bclk);
    out_ready = 1'b1;
    repeat (20) @(negedge bclk);
    total++; if (got_d.size() != FL) begin bad++; $display("FAIL bp_count: got %0d want %0d", got_d.size(), FL); end
    for (int i = 0; i < got_d.size() && i < FL; i++) begin
      total++;
      if (got_d[i] !== 16'(16'h0A01 + i) || got_l[i] !== (i == FL - 1)) begin
        bad++;
        $display("FAIL bp_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], 16'(16'h0A01 + i), (i == FL - 1));
      end
    end
  endtask

  task automatic test_overflow();
    clear_got();
    out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      send_sample(16'(i), 2, 2);
      #1;
      if (i == 16) begin
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_at16: got %b want 0", overflow); end
      end
      if (i == 17) begin
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_at17: got %b want 1", overflow); end
      end
    end
    total++; if (got_d.size() != 0) begin bad++; $display("FAIL ovf_stalled: got %0d beats want 0", got_d.size()); end
    @(negedge bclk);
    out_ready = 1'b1;
    for (int k = 0; k < 400 && got_d.size() < 2 * FL; k++) @(negedge bclk);
    repeat (30) @(negedge bclk);
    total++; if (got_d.size() != 2 * FL) begin bad++; $display("FAIL ovf_count: got %0d want %0d", got_d.size(), 2 * FL); end
    for (int i = 0; i < got_d.size() && i < 2 * FL; i++) begin
      total++;
      if (got_d[i] !== 16'(i + 1) || got_l[i] !== (i == 7 || i == 15)) begin
        bad++;
        $display("FAIL ovf_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], 16'(i + 1), (i == 7 || i == 15));
      end
    end
    #1;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    @(negedge bclk);
    clear_overflow = 1'b1;
    @(negedge bclk);
    clear_overflow = 1'b0;
    #1;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_reset_mid();
    clear_got();
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send_sample(16'(16'h0F00 + i), 2, 2);
    @(negedge bclk);
    reset = 1'b1;
    @(negedge bclk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rmid_last: got %b want 0", out_last); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL rmid_data: got %h want 0000", out_data); end
    @(negedge bclk);
    reset = 1'b0;
    clear_got();
    for (int i = 1; i <= FL; i++) send_sample(16'(16'h0100 + i), 2, 2);
    for (int k = 0; k < 400 && got_d.size() < FL; k++) @(negedge bclk);
    repeat (30) @(negedge bclk);
    total++; if (got_d.size() != FL) begin bad++; $display("FAIL rmid_count: got %0d want %0d", got_d.size(), FL); end
    for (int i = 0; i < got_d.size() && i < FL; i++) begin
      total++;
      if (got_d[i] !== 16'(16'h0101 + i) || got_l[i] !== (i == FL - 1)) begin
        bad++;
        $display("FAIL rmid_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], 16'(16'h0101 + i), (i == FL - 1));
      end
    end
  endtask

  task automatic test_reset_high();
    clear_got();
    out_ready = 1'b1;
    @(negedge bclk);
    reset    = 1'b1;
    in_data  = 16'h0BAD;
    in_valid = 1'b1;
    repeat (2) @(negedge bclk);
    reset = 1'b0;
    repeat (10) @(negedge bclk);
    in_valid = 1'b0;
    repeat (5) @(negedge bclk);
    for (int i = 1; i <= FL; i++) send_sample(16'(16'h0200 + i), 2, 2);
    for (int k = 0; k < 400 && got_d.size() < FL; k++) @(negedge bclk);
    repeat (30) @(negedge bclk);
    total++; if (got_d.size() != FL) begin bad++; $display("FAIL rhigh_count: got %0d want %0d", got_d.size(), FL); end
    for (int i = 0; i < got_d.size() && i < FL; i++) begin
      total++;
      if (got_d[i] !== 16'(16'h0201 + i) || got_l[i] !== (i == FL - 1)) begin
        bad++;
        $display("FAIL rhigh_beat%0d: got %h/%b want %h/%b", i, got_d[i], got_l[i], 16'(16'h0201 + i), (i == FL - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_level();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_reset_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mic_frame_buffer.md
Name: mic_frame_buffer

Overview:
- Sits directly downstream of the microphone deserialiser and feeds the FFT input stage.
- Converts the deserialiser's level-style sample-valid into one capture per sample.
- Collects FRAME_LEN consecutive samples into a ping-pong frame buffer.
- Streams each complete frame out over a valid/ready interface, with a last-beat marker for FFT frame alignment.

Parameters:
- W, 16: sample width in bits; matches deserialiser output width.
- FRAME_LEN, 256: samples per frame; power of two, minimum 4.
- ADDR_W, $clog2(FRAME_LEN): derived index width; not overridden by users.

Ports:
- bclk  input  1  audio bit clock; the only clock; every register on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  deserialiser valid; a level that stays high for many cycles after each sample completes.
- in_data  input  W  deserialiser sample, MSB-first two's complement; stable while in_valid is high.
- out_valid  output  1  frame sample available.
- out_ready  input  1  consumer accepts the beat when out_valid & out_ready.
- out_data  output  W  frame sample.
- out_last  output  1  high on the final beat (index FRAME_LEN-1) of each frame.
- overflow  output  1  sticky; a sample was dropped because no bank was free.
- clear_overflow  input  1  clears overflow.

Behaviour:
- Reset (sync, active-high):
  - out_valid=0, out_last=0, out_data=0, overflow=0.
  - Both banks empty; wr_bank=rd_bank=0; wr_idx=0.
  - in_valid_q=1, so in_valid already high at reset release is not captured.
  - Reset mid-frame or mid-stream discards all buffered data; no partial frame is ever emitted.
- Capture:
  - capture = in_valid & ~in_valid_q. in_valid_q is in_valid registered every cycle.
  - Exactly one capture per rising edge of in_valid, however long in_valid stays high.
- Write side, on each capture:
  - If bank wr_bank is EMPTY: write in_data to mem[wr_bank][wr_idx].
  - If wr_idx==FRAME_LEN-1 on that write: mark the bank FULL, toggle wr_bank, set wr_idx=0. Otherwise wr_idx+1.
  - If bank wr_bank is FULL or being read: drop the sample, set overflow=1, leave wr_idx at 0.
  - Consequence: every emitted frame is FRAME_LEN contiguous samples starting at a bank boundary.
- Read FSM: IDLE -> PRIME -> STREAM.
  - IDLE: wait until bank rd_bank is FULL.
  - PRIME: one cycle of memory read latency for index 0. out_valid is still 0.
  - STREAM: out_valid=1 and out_data=mem[rd_bank][rd_idx]; out_last=(rd_idx==FRAME_LEN-1).
  - On handshake with rd_idx<FRAME_LEN-1: advance rd_idx.
  - On handshake of the last beat: mark bank rd_bank EMPTY, toggle rd_bank, rd_idx=0.
  - After the last beat: go to PRIME if the other bank is already FULL, else IDLE.
- Latency: out_valid rises exactly 2 bclk cycles after the capture cycle of a frame's final sample, provided the read side was IDLE.
- Throughput: with out_ready held high, one beat per cycle within a frame. Use a prefetch/skid register; no bubbles between beats of the same frame.
- Handshake rules:
  - While out_valid & ~out_ready, out_data and out_last hold stable and out_valid stays high.
  - out_valid never depends combinationally on out_ready.
- Simultaneous events:
  - Bank release and a capture targeting that bank in the same cycle: the release takes effect at the clock edge, the capture sees the bank not empty, and the sample is dropped with overflow set.
  - clear_overflow and a new drop in the same cycle: set wins; overflow=1.
- Storage: 2*FRAME_LEN x W, inferred as synchronous-read RAM (1-cycle read latency).

Test Plan (FRAME_LEN=8 unless noted):
- Basic frame:
  - Stimulus: samples 0x0001..0x0008, in_valid high 20 cycles then low 12 per sample; out_ready=1.
  - Response: 8 consecutive beats 0x0001..0x0008; out_last only on 0x0008; out_valid first high 2 cycles after the 8th capture.
- Level valid:
  - Stimulus: in_valid held high 200 cycles with in_data fixed at 0x1234, then 7 more normal samples.
  - Response: exactly one 0x1234 beat in the emitted frame.
- Backpressure:
  - Stimulus: random out_ready (~50%) during streaming.
  - Response: out_data/out_last stable whenever out_valid & ~out_ready; all 8 values emitted in order, none lost or duplicated.
- Overflow:
  - Stimulus: out_ready=0; feed 20 samples 1..20. Then out_ready=1. Then pulse clear_overflow.
  - Response: overflow=1 after sample 17. After out_ready=1: beats 1..16 with out_last on 8 and 16; samples 17..20 never appear. clear_overflow returns overflow to 0.
- Reset mid-frame:
  - Stimulus: 5 samples, reset 1 cycle, then samples 0x0101..0x0108.
  - Response: outputs 0 during reset; next frame is exactly 0x0101..0x0108.
- Reset with input high:
  - Stimulus: in_valid=1 across reset release, then low and high again.
  - Response: no capture until the first 0->1 transition after reset.
